// File: rtl/voice_pkg.sv
// Shared types and widths for the voice allocator and its voice slots.
package voice_pkg;

  localparam int unsigned NOTE_W    = 7;
  localparam int unsigned VEL_W     = 7;
  localparam int unsigned PROG_W    = 7;
  localparam int unsigned AGE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Latched MIDI event
  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
    logic [PROG_W-1:0] prog;
  } note_ev_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: gate, note/vel/program, saturating age and (with
// VOICE_ALLOC_SUSTAIN_EN) the sustain-held bit.
module voice_slot
  import voice_pkg::*;
#(
  parameter int unsigned AGE_W = AGE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_age_inc,
  input  logic              i_release,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic              i_hold,
  input  logic              i_sus_release,
`endif
  input  logic [NOTE_W-1:0] i_note,
  input  logic [VEL_W-1:0]  i_vel,
  input  logic [PROG_W-1:0] i_program,
  input  logic [NOTE_W-1:0] i_cmp_note,
  output logic              o_active,
  output logic [NOTE_W-1:0] o_note,
  output logic [VEL_W-1:0]  o_vel,
  output logic [PROG_W-1:0] o_program,
  output logic [AGE_W-1:0]  o_age,
  output logic              o_match_c,
  output logic              o_free_c
);

  logic              r_active;
  logic [NOTE_W-1:0] r_note;
  logic [VEL_W-1:0]  r_vel;
  logic [PROG_W-1:0] r_program;
  logic [AGE_W-1:0]  r_age;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic              r_held;
`endif

  // A load (allocate or retrigger) takes priority over every other update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_note    <= '0;
      r_vel     <= '0;
      r_program <= '0;
      r_age     <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      r_held    <= 1'b0;
`endif
    end else if (i_load) begin
      r_active  <= 1'b1;
      r_note    <= i_note;
      r_vel     <= i_vel;
      r_program <= i_program;
      r_age     <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      r_held    <= 1'b0;
`endif
    end else begin
      if (i_age_inc && r_active && (r_age != '1)) r_age <= r_age + AGE_W'(1);
      if (i_release) r_active <= 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      if (i_hold) r_held <= 1'b1;
      if (i_sus_release && r_held) begin
        r_active <= 1'b0;
        r_held   <= 1'b0;
      end
`endif
    end
  end

  assign o_active  = r_active;
  assign o_note    = r_note;
  assign o_vel     = r_vel;
  assign o_program = r_program;
  assign o_age     = r_age;
  assign o_match_c = r_active && (r_note == i_cmp_note);
  assign o_free_c  = ~r_active;

endmodule

// File: rtl/voice_allocator.sv
// MIDI note-event to voice allocator: IDLE/SCAN/COMMIT FSM over NUM_VOICES slots.
// Optional sustain pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VOICE_W    = 2,
  parameter int unsigned AGE_W      = AGE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_note_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  input  logic [PROG_W-1:0]            ev_program,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                         sustain,
`endif
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
  output logic [NUM_VOICES*PROG_W-1:0] voice_program,
  output logic                         alloc_valid,
  output logic [VOICE_W-1:0]           alloc_voice,
  output logic                         alloc_stolen
);

  state_e               r_state, w_state_nxt;
  logic                 r_ev_ready, r_alloc_valid, r_alloc_stolen;
  logic [VOICE_W-1:0]   r_alloc_voice;
  note_ev_t             r_ev;
  logic [VOICE_W-1:0]   r_scan_idx;
  logic                 r_match_found, r_free_found;
  logic [VOICE_W-1:0]   r_match_idx, r_free_idx, r_old_idx;
  logic [AGE_W-1:0]     r_old_age;

  logic                 w_accept, w_commit;
  logic                 w_note_on, w_stolen, w_do_alloc, w_do_off, w_do_release;
  logic [VOICE_W-1:0]   w_sel;
  logic [NUM_VOICES-1:0] w_match, w_free;
  logic [AGE_W-1:0]     w_age [NUM_VOICES];
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic                 r_sus, r_rel_pend;
  logic                 w_sus_fall, w_sus_rel, w_do_hold;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ev_ready     <= 1'b1;
      r_alloc_valid  <= 1'b0;
      r_alloc_stolen <= 1'b0;
      r_alloc_voice  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ev_ready     <= (w_state_nxt == ST_IDLE);
      r_alloc_valid  <= w_do_alloc;
      r_alloc_stolen <= w_do_alloc & w_stolen;
      if (w_do_alloc) r_alloc_voice <= w_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ev_valid && r_ev_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_scan_idx == VOICE_W'(NUM_VOICES - 1)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Event latch and one-voice-per-cycle scan accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev          <= '0;
      r_scan_idx    <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
      r_match_idx   <= '0;
      r_free_idx    <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
    end else if (w_accept) begin
      r_ev          <= '{on: ev_note_on, note: ev_note, vel: ev_vel, prog: ev_program};
      r_scan_idx    <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
    end else if (r_state == ST_SCAN) begin
      r_scan_idx <= r_scan_idx + VOICE_W'(1);
      if (w_match[r_scan_idx] && !r_match_found) begin
        r_match_found <= 1'b1;
        r_match_idx   <= r_scan_idx;
      end
      if (w_free[r_scan_idx] && !r_free_found) begin
        r_free_found <= 1'b1;
        r_free_idx   <= r_scan_idx;
      end
      // Strict compare keeps the lowest index on equal ages
      if (w_age[r_scan_idx] > r_old_age) begin
        r_old_age <= w_age[r_scan_idx];
        r_old_idx <= r_scan_idx;
      end
    end
  end

  // Commit decision: retrigger > free voice > steal oldest
  always_comb begin
    w_note_on  = r_ev.on && (r_ev.vel != '0);
    w_sel      = r_old_idx;
    w_stolen   = 1'b0;
    if (r_match_found)     w_sel = r_match_idx;
    else if (r_free_found) w_sel = r_free_idx;
    else                   w_stolen = 1'b1;
    w_do_alloc = w_commit && w_note_on;
    w_do_off   = w_commit && !w_note_on && r_match_found;
  end

`ifdef VOICE_ALLOC_SUSTAIN_EN
  // Pedal release is deferred until the FSM is back in IDLE
  assign w_sus_fall   = r_sus & ~sustain;
  assign w_sus_rel    = (w_sus_fall | r_rel_pend) & (r_state == ST_IDLE);
  assign w_do_hold    = w_do_off & sustain;
  assign w_do_release = w_do_off & ~sustain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sus      <= 1'b0;
      r_rel_pend <= 1'b0;
    end else begin
      r_sus      <= sustain;
      r_rel_pend <= (w_sus_fall | r_rel_pend) & ~w_sus_rel;
    end
  end
`else
  assign w_do_release = w_do_off;
`endif

  for (genvar i = 0; i < int'(NUM_VOICES); i++) begin : g_slot
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk           (clk),
      .rst           (rst),
      .i_load        (w_do_alloc && (w_sel == VOICE_W'(i))),
      .i_age_inc     (w_do_alloc),
      .i_release     (w_do_release && (r_match_idx == VOICE_W'(i))),
`ifdef VOICE_ALLOC_SUSTAIN_EN
      .i_hold        (w_do_hold && (r_match_idx == VOICE_W'(i))),
      .i_sus_release (w_sus_rel),
`endif
      .i_note        (r_ev.note),
      .i_vel         (r_ev.vel),
      .i_program     (r_ev.prog),
      .i_cmp_note    (r_ev.note),
      .o_active      (voice_active[i]),
      .o_note        (voice_note[NOTE_W*i +: NOTE_W]),
      .o_vel         (voice_vel[VEL_W*i +: VEL_W]),
      .o_program     (voice_program[PROG_W*i +: PROG_W]),
      .o_age         (w_age[i]),
      .o_match_c     (w_match[i]),
      .o_free_c      (w_free[i])
    );
  end

  assign ev_ready     = r_ev_ready;
  assign alloc_valid  = r_alloc_valid;
  assign alloc_voice  = r_alloc_voice;
  assign alloc_stolen = r_alloc_stolen;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (4 voices); the sustain
// scenario is exercised when VOICE_ALLOC_SUSTAIN_EN is defined.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid, ev_note_on;
  logic [6:0]  ev_note, ev_vel, ev_program;
  logic        ev_ready;
  logic [3:0]  voice_active;
  logic [27:0] voice_note, voice_vel, voice_program;
  logic        alloc_valid, alloc_stolen;
  logic [1:0]  alloc_voice;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic        sustain;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(4), .VOICE_W(2), .AGE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_note_on    (ev_note_on),
    .ev_note       (ev_note),
    .ev_vel        (ev_vel),
    .ev_program    (ev_program),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain       (sustain),
`endif
    .voice_active  (voice_active),
    .voice_note    (voice_note),
    .voice_vel     (voice_vel),
    .voice_program (voice_program),
    .alloc_valid   (alloc_valid),
    .alloc_voice   (alloc_voice),
    .alloc_stolen  (alloc_stolen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one event (ev_ready assumed high), then wait up to 20 edges for ev_ready
  task automatic run_ev(input logic on, input logic [6:0] n, input logic [6:0] v,
                        input logic [6:0] p, output int lat, output logic av,
                        output logic [1:0] vc, output logic st);
    ev_valid = 1'b1; ev_note_on = on; ev_note = n; ev_vel = v; ev_program = p;
    lat = -1; av = 1'b0; vc = 2'd0; st = 1'b0;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (alloc_valid) begin
        av = 1'b1; vc = alloc_voice; st = alloc_stolen;
      end
      if (ev_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  // Note-on that must allocate: check latency, voice and stolen flag
  task automatic note_on(input string tag, input logic [6:0] n, input logic [6:0] v,
                         input logic [6:0] p, input logic [1:0] exp_v, input logic exp_st);
    int lat; logic av; logic [1:0] vc; logic st;
    check({tag, "_ready"}, 32'(ev_ready), 32'd1);
    run_ev(1'b1, n, v, p, lat, av, vc, st);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_alloc"}, 32'(av), 32'd1);
    check({tag, "_voice"}, 32'(vc), 32'(exp_v));
    check({tag, "_stolen"}, 32'(st), 32'(exp_st));
  endtask

  // Event that must not allocate (note-off or velocity-0 note-on)
  task automatic no_alloc(input string tag, input logic on, input logic [6:0] n,
                          input logic [3:0] exp_act);
    int lat; logic av; logic [1:0] vc; logic st;
    run_ev(on, n, 7'd0, 7'd0, lat, av, vc, st);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_noalloc"}, 32'(av), 32'd0);
    check({tag, "_active"}, 32'(voice_active), 32'(exp_act));
  endtask

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_note_on = 1'b0;
    ev_note = '0; ev_vel = '0; ev_program = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 32'(ev_ready), 32'd1);
    check("rst_active", 32'(voice_active), 32'd0);
    check("rst_alloc", 32'(alloc_valid), 32'd0);
    check("rst_note", voice_note, 32'd0);

    // 1: first allocation
    note_on("t1", 7'd60, 7'd100, 7'd3, 2'd0, 1'b0);
    check("t1_note0", 32'(voice_note[6:0]), 32'd60);
    check("t1_vel0", 32'(voice_vel[6:0]), 32'd100);
    check("t1_prog0", 32'(voice_program[6:0]), 32'd3);
    check("t1_active", 32'(voice_active), 32'h1);
    @(posedge clk); #1;
    check("t1_pulse1", 32'(alloc_valid), 32'd0);

    // 2: fill remaining voices, then steal the oldest (voice 0)
    note_on("t2a", 7'd62, 7'd90, 7'd4, 2'd1, 1'b0);
    note_on("t2b", 7'd64, 7'd80, 7'd5, 2'd2, 1'b0);
    note_on("t2c", 7'd67, 7'd70, 7'd6, 2'd3, 1'b0);
    check("t2_active", 32'(voice_active), 32'hf);
    check("t2_note3", 32'(voice_note[27:21]), 32'd67);
    note_on("t2s", 7'd72, 7'd50, 7'd7, 2'd0, 1'b1);
    check("t2s_note0", 32'(voice_note[6:0]), 32'd72);

    // 3: retrigger 62 on voice 1 with new vel/program
    note_on("t3", 7'd62, 7'd33, 7'd9, 2'd1, 1'b0);
    check("t3_active", 32'(voice_active), 32'hf);
    check("t3_vel1", 32'(voice_vel[13:7]), 32'd33);
    check("t3_prog1", 32'(voice_program[13:7]), 32'd9);

    // 4: note-off 64 frees voice 2; velocity-0 note-on 64 then has no match
    no_alloc("t4off", 1'b0, 7'd64, 4'b1011);
    check("t4_keep2", 32'(voice_note[20:14]), 32'd64);
    no_alloc("t4v0", 1'b1, 7'd64, 4'b1011);
    note_on("t4free", 7'd65, 7'd40, 7'd1, 2'd2, 1'b0);
    // ages now v0=2 v1=1 v2=0 v3=3 -> voice 3 is stolen
    note_on("t4steal", 7'd70, 7'd41, 7'd2, 2'd3, 1'b1);
    check("t4_note3", 32'(voice_note[27:21]), 32'd70);

    // 5: reset while in SCAN drops the event; held ev_valid is accepted afterwards
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd50; ev_vel = 7'd20; ev_program = 7'd8;
    @(posedge clk); #1;
    check("t5_busy", 32'(ev_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ready", 32'(ev_ready), 32'd1);
    check("t5_active", 32'(voice_active), 32'd0);
    check("t5_note", voice_note, 32'd0);
    check("t5_alloc", 32'(alloc_valid), 32'd0);
    rst = 1'b0;
    note_on("t5re", 7'd50, 7'd20, 7'd8, 2'd0, 1'b0);
    check("t5_note0", 32'(voice_note[6:0]), 32'd50);

    // 6: sustain pedal behaviour (or immediate note-off without it)
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain = 1'b1;
    @(posedge clk); #1;
    no_alloc("t6hold", 1'b0, 7'd50, 4'b0001);
    sustain = 1'b0;
    @(posedge clk); #1;
    check("t6_release", 32'(voice_active), 32'd0);
`else
    no_alloc("t6off", 1'b0, 7'd50, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
